enet_rmii_rx_deframer: RTL and testbench
========================================

Name: enet_rmii_rx_deframer

Overview:
- Parametrised next-generation RMII receive front end for the enet peripheral.
- Runs entirely in the RMII reference-clock domain and supports 10/100 Mb/s.
- Strips preamble/SFD and assembles LSB-first dibits into OUT_W-bit words, delivered as single-cycle strobes with SOF/EOF/error framing.
- Adds handling the previous converter lacked: false-carrier detection, alignment/jabber errors, and CRS_DV toggle handling. Feeds the MAC RX FIFO directly.

Parameters:
- SYNC_LV, 2, input synchroniser depth (≥2)
- OUT_W, 8, output word width; legal values 4 (nibble) or 8 (byte)
- DIV_10T, 10, rmii_ref_clk cycles per RMII sample in 10 Mb/s mode (≥2)
- MAX_WORDS, 1536, word count that triggers a jabber abort

Ports:
- rmii_ref_clk  in  1  sole clock, 50 MHz
- rst_ref_n  in  1  reset; synchronous, active-low
- rmii_10T  in  1  1 = 10 Mb/s mode, 0 = 100 Mb/s mode
- rmii_rx_crs_dv  in  1  RMII CRS_DV (asynchronous)
- rmii_rxd  in  2  RMII RXD (asynchronous)
- rx_data  out  OUT_W  assembled word; bit 0 = first received bit
- rx_valid  out  1  one-cycle strobe; rx_data valid
- rx_sof  out  1  qualifies rx_valid; first word of frame
- rx_eof  out  1  one-cycle end-of-frame strobe; never coincides with rx_valid
- rx_err  out  1  qualifies rx_eof; frame bad
- rx_false_carrier  out  1  one-cycle strobe when a false-carrier event ends

Behaviour:
- Reset: every output and all internal state are 0; FSM is IDLE.
- Synchroniser: crs_dv and rxd pass through SYNC_LV flops (reset value 0), giving s_dv and s_rxd.
- Sample enable:
  - samp_en = 1 in 100 Mb/s mode.
  - In 10 Mb/s mode, samp_en = 1 when div_cnt == DIV_10T-1. div_cnt counts 0..DIV_10T-1 and wraps.
  - In 100 Mb/s mode div_cnt is held at 0.
  - Any change of rmii_10T clears div_cnt and forces IDLE, with no strobes.
- Delay stage: on samp_en, {d_dv, d_rxd} <= {s_dv, s_rxd}.
- Commit and end-of-carrier (CRS_DV toggle handling):
  - commit = samp_en & (d_dv | s_dv).
  - end_c = samp_en & !d_dv & !s_dv.
- FSM states: IDLE, PREAMBLE, DATA, FALSE_CARRIER, DRAIN.
  - IDLE, on samp_en & s_dv:
    - s_rxd = 01 → PREAMBLE
    - s_rxd = 10 → FALSE_CARRIER
    - s_rxd = 00 or 11 → stay in IDLE
  - PREAMBLE, on commit:
    - d_rxd = 01 → stay
    - d_rxd = 11 → DATA; dibit count cleared, sof_pend set
    - any other value → IDLE, silently
  - PREAMBLE, on end_c → IDLE, silently.
  - DATA, on commit:
    - Shift d_rxd into the assembly register at position 2*cnt.
    - When cnt reaches OUT_W/2-1: assert rx_valid for one cycle, rx_sof = sof_pend; clear sof_pend and cnt; increment word count.
  - DATA, on end_c:
    - rx_eof for one cycle.
    - rx_err = 1 if cnt != 0 (partial word) or sof_pend is still set (no data words); otherwise 0.
    - Next state IDLE.
  - DATA, word count reaching MAX_WORDS on a completed word: that word is emitted, then rx_eof with rx_err = 1 on the next cycle, then DRAIN.
  - FALSE_CARRIER, on end_c: rx_false_carrier pulses for one cycle → IDLE. No rx_eof.
  - DRAIN, on end_c → IDLE, with no strobes.
- Latency, 100 Mb/s mode: completing dibit on pins in cycle t → rx_valid high in cycle t+SYNC_LV+2. In 10 Mb/s mode the same, measured in samples.
- Simultaneous events: end_c and commit are mutually exclusive by construction.
- Reset asserted mid-frame: outputs are cleared on the next edge; no rx_eof is emitted.
- Word count: 11-bit, saturating; compared with ≥ MAX_WORDS.

Optional Feature:
- ENET_RX_STAT_EN defined:
  - Adds outputs stat_frames[15:0] (good EOFs), stat_errs[15:0] (EOFs with rx_err) and stat_fc[15:0] (false-carrier events).
  - Each counter saturates at 16'hFFFF and resets to 0.
  - Adds input stat_clr; when high, all three counters are zeroed that cycle, with priority over increments.
- Macro undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- enet_pkg: FSM state encoding, dibit constants (PRE = 2'b01, SFD_LAST = 2'b11, FC = 2'b10), and legal OUT_W values.
- Synchronisers use the existing general_sync; state flops use FF_D_with_wen.
- One natural sub-module, enet_rx_samp_gen: the div_cnt sample-enable generator with mode-change clear. It is reused by the TX side.

Test Plan:
- 100 Mb/s, OUT_W=8: crs_dv high with 7×0x55, 0xD5, 0xA5, 0x3C, then crs_dv low. Expect rx_valid twice: 0xA5 with rx_sof=1, then 0x3C; then rx_eof with rx_err=0. First rx_valid occurs SYNC_LV+2 cycles after the 4th dibit of 0xA5.
- 10 Mb/s, same frame, each dibit held 10 clocks: same words. Every strobe is exactly one cycle; gap between the two rx_valid strobes is 40 cycles.
- CRS_DV toggle: after 0xA5, crs_dv goes 0,1,0,1 on alternate dibits while the data 0x3C continues. Expect 0x3C delivered intact; rx_eof only after two consecutive low samples.
- Partial word: frame ends one dibit after 0xA5. Expect rx_eof with rx_err=1 and no extra rx_valid.
- False carrier: crs_dv high with rxd=10 for 8 samples, then low. Expect rx_false_carrier pulse and no rx_valid/rx_eof. With ENET_RX_STAT_EN, stat_fc = 1.
- Jabber, MAX_WORDS=4: frame with 6 data bytes. Expect 4 rx_valid, then rx_eof with rx_err=1, and no further strobes until carrier ends. A following good frame is received normally.

Source files
------------

// File: rtl/enet_pkg.sv
// enet_pkg: encodings shared by the RMII receive and transmit paths.
package enet_pkg;

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_PREAMBLE      = 3'd1,
      ST_DATA          = 3'd2,
      ST_FALSE_CARRIER = 3'd3,
      ST_DRAIN         = 3'd4
   } rx_state_e;

   localparam logic [1:0] DIBIT_PRE      = 2'b01;
   localparam logic [1:0] DIBIT_SFD_LAST = 2'b11;
   localparam logic [1:0] DIBIT_FC       = 2'b10;

   localparam int OUT_W_NIBBLE = 4;
   localparam int OUT_W_BYTE   = 8;

endpackage

// File: rtl/enet_rx_samp_gen.sv
// enet_rx_samp_gen: RMII sample-enable generator (every clock at 100 Mb/s,
// every DIV_10T clocks at 10 Mb/s); a mode change restarts the divider.
module enet_rx_samp_gen #(
   parameter int DIV_10T = 10
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic mode_10t_i,
   output logic samp_en_o,
   output logic mode_chg_o
);

   localparam int CW = (DIV_10T > 1) ? $clog2(DIV_10T) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_10T - 1);

   logic          mode_q;
   logic [CW-1:0] div_cnt_q, div_cnt_d;

   assign mode_chg_o = (mode_10t_i != mode_q);

   always_comb begin
      div_cnt_d = '0;
      samp_en_o = 1'b0;
      if (!mode_chg_o) begin
         if (mode_q) begin
            samp_en_o = (div_cnt_q == DIV_LAST);
            div_cnt_d = samp_en_o ? '0 : div_cnt_q + 1'b1;
         end else begin
            samp_en_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mode_q    <= 1'b0;
         div_cnt_q <= '0;
      end else begin
         mode_q    <= mode_10t_i;
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/enet_rmii_rx_deframer.sv
// enet_rmii_rx_deframer: RMII RX preamble/SFD stripper and dibit-to-word assembler.
// Optional statistics counters are built when ENET_RX_STAT_EN is defined.
//
// state            | meaning
// ST_IDLE          | no carrier; waiting for preamble or false-carrier dibit
// ST_PREAMBLE      | receiving 01 dibits, waiting for the 11 that ends the SFD
// ST_DATA          | assembling payload dibits into words
// ST_FALSE_CARRIER | carrier opened with 10; waiting for it to end
// ST_DRAIN         | jabber abort reported; discarding until carrier ends
module enet_rmii_rx_deframer import enet_pkg::*; #(
   parameter int SYNC_LV   = 2,
   parameter int OUT_W     = 8,
   parameter int DIV_10T   = 10,
   parameter int MAX_WORDS = 1536
) (
   input  logic             rmii_ref_clk,
   input  logic             rst_ref_n,
   input  logic             rmii_10T,
   input  logic             rmii_rx_crs_dv,
   input  logic [1:0]       rmii_rxd,
`ifdef ENET_RX_STAT_EN
   input  logic             stat_clr,
   output logic [15:0]      stat_frames,
   output logic [15:0]      stat_errs,
   output logic [15:0]      stat_fc,
`endif
   output logic [OUT_W-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_sof,
   output logic             rx_eof,
   output logic             rx_err,
   output logic             rx_false_carrier
);

   localparam int DIBITS = (OUT_W == OUT_W_NIBBLE) ? OUT_W_NIBBLE / 2 : OUT_W_BYTE / 2;
   localparam logic [1:0]  CNT_LAST = 2'(DIBITS - 1);
   localparam logic [10:0] WC_MAX   = 11'(MAX_WORDS);

   logic [SYNC_LV-1:0]      sync_dv_q;
   logic [SYNC_LV-1:0][1:0] sync_rxd_q;
   logic                    s_dv, d_dv_q;
   logic [1:0]              s_rxd, d_rxd_q;
   logic                    samp_en, mode_chg, commit, end_c;

   rx_state_e        state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [OUT_W-1:0] asm_q, asm_d, data_q, data_d, word;
   logic [10:0]      wc_q, wc_d, wc_inc;
   logic             sof_pend_q, sof_pend_d, jab_q, jab_d;
   logic             valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
   logic             err_q, err_d, fc_q, fc_d;

   enet_rx_samp_gen #(.DIV_10T(DIV_10T)) u_samp_gen (
      .clk_i      (rmii_ref_clk),
      .rst_n_i    (rst_ref_n),
      .mode_10t_i (rmii_10T),
      .samp_en_o  (samp_en),
      .mode_chg_o (mode_chg)
   );

   assign s_dv   = sync_dv_q[SYNC_LV-1];
   assign s_rxd  = sync_rxd_q[SYNC_LV-1];
   // Looking one sample back and one ahead rides over CRS_DV toggling at end of frame.
   assign commit = samp_en & (d_dv_q | s_dv);
   assign end_c  = samp_en & ~d_dv_q & ~s_dv;
   assign wc_inc = (wc_q == 11'h7FF) ? wc_q : wc_q + 11'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      data_d     = data_q;
      wc_d       = wc_q;
      sof_pend_d = sof_pend_q;
      jab_d      = jab_q;
      valid_d    = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      err_d      = 1'b0;
      fc_d       = 1'b0;
      word       = asm_q;
      word[{cnt_q, 1'b0} +: 2] = d_rxd_q;
      unique case (state_q)
         ST_IDLE: begin
            if (samp_en && s_dv) begin
               if (s_rxd == DIBIT_PRE)     state_d = ST_PREAMBLE;
               else if (s_rxd == DIBIT_FC) state_d = ST_FALSE_CARRIER;
            end
         end
         ST_PREAMBLE: begin
            if (commit) begin
               if (d_rxd_q == DIBIT_SFD_LAST) begin
                  state_d    = ST_DATA;
                  cnt_d      = '0;
                  asm_d      = '0;
                  wc_d       = '0;
                  sof_pend_d = 1'b1;
               end else if (d_rxd_q != DIBIT_PRE) begin
                  state_d = ST_IDLE;
               end
            end else if (end_c) begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (jab_q) begin
               eof_d   = 1'b1;
               err_d   = 1'b1;
               jab_d   = 1'b0;
               state_d = ST_DRAIN;
            end else if (commit) begin
               asm_d = word;
               if (cnt_q == CNT_LAST) begin
                  valid_d    = 1'b1;
                  sof_d      = sof_pend_q;
                  data_d     = word;
                  sof_pend_d = 1'b0;
                  cnt_d      = '0;
                  wc_d       = wc_inc;
                  jab_d      = (wc_inc >= WC_MAX);
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (end_c) begin
               eof_d   = 1'b1;
               err_d   = (cnt_q != 2'd0) || sof_pend_q;
               state_d = ST_IDLE;
            end
         end
         ST_FALSE_CARRIER: begin
            if (end_c) begin
               fc_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (end_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (mode_chg) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         sof_pend_d = 1'b0;
         jab_d      = 1'b0;
         eof_d      = 1'b0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge rmii_ref_clk) begin
      if (!rst_ref_n) begin
         sync_dv_q  <= '0;
         sync_rxd_q <= '0;
         d_dv_q     <= 1'b0;
         d_rxd_q    <= '0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         asm_q      <= '0;
         data_q     <= '0;
         wc_q       <= '0;
         sof_pend_q <= 1'b0;
         jab_q      <= 1'b0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         err_q      <= 1'b0;
         fc_q       <= 1'b0;
      end else begin
         sync_dv_q  <= {sync_dv_q[SYNC_LV-2:0], rmii_rx_crs_dv};
         sync_rxd_q <= {sync_rxd_q[SYNC_LV-2:0], rmii_rxd};
         if (samp_en) begin
            d_dv_q  <= s_dv;
            d_rxd_q <= s_rxd;
         end
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         asm_q      <= asm_d;
         data_q     <= data_d;
         wc_q       <= wc_d;
         sof_pend_q <= sof_pend_d;
         jab_q      <= jab_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         err_q      <= err_d;
         fc_q       <= fc_d;
      end
   end

   assign rx_data          = data_q;
   assign rx_valid         = valid_q;
   assign rx_sof           = sof_q;
   assign rx_eof           = eof_q;
   assign rx_err           = err_q;
   assign rx_false_carrier = fc_q;

`ifdef ENET_RX_STAT_EN
   logic [15:0] frames_q, errs_q, fc_cnt_q;

   always_ff @(posedge rmii_ref_clk) begin
      if (!rst_ref_n || stat_clr) begin
         frames_q <= '0;
         errs_q   <= '0;
         fc_cnt_q <= '0;
      end else begin
         if (eof_q && !err_q && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
         if (eof_q && err_q && errs_q != 16'hFFFF)    errs_q   <= errs_q + 16'd1;
         if (fc_q && fc_cnt_q != 16'hFFFF)            fc_cnt_q <= fc_cnt_q + 16'd1;
      end
   end

   assign stat_frames = frames_q;
   assign stat_errs   = errs_q;
   assign stat_fc     = fc_cnt_q;
`endif

endmodule

// File: tb/tb_enet_rmii_rx_deframer.sv
// tb_enet_rmii_rx_deframer: frame-level reference model vs. observed strobe stream.
// Statistics checks are compiled in when ENET_RX_STAT_EN is defined.
module tb_enet_rmii_rx_deframer;

   localparam int SYNC_LV   = 2;
   localparam int OUT_W     = 8;
   localparam int DIV_10T   = 10;
   localparam int MAX_WORDS = 4;
   localparam logic [1:0] K_VAL = 2'd1;
   localparam logic [1:0] K_EOF = 2'd2;
   localparam logic [1:0] K_FC  = 2'd3;

   logic             rmii_ref_clk = 1'b0;
   logic             rst_ref_n, rmii_10T, rmii_rx_crs_dv;
   logic [1:0]       rmii_rxd;
   logic [OUT_W-1:0] rx_data;
   logic             rx_valid, rx_sof, rx_eof, rx_err, rx_false_carrier;
`ifdef ENET_RX_STAT_EN
   logic             stat_clr;
   logic [15:0]      stat_frames, stat_errs, stat_fc;
`endif

   always #10 rmii_ref_clk = ~rmii_ref_clk;

   enet_rmii_rx_deframer #(
      .SYNC_LV(SYNC_LV), .OUT_W(OUT_W), .DIV_10T(DIV_10T), .MAX_WORDS(MAX_WORDS)
   ) dut (
      .rmii_ref_clk     (rmii_ref_clk),
      .rst_ref_n        (rst_ref_n),
      .rmii_10T         (rmii_10T),
      .rmii_rx_crs_dv   (rmii_rx_crs_dv),
      .rmii_rxd         (rmii_rxd),
`ifdef ENET_RX_STAT_EN
      .stat_clr         (stat_clr),
      .stat_frames      (stat_frames),
      .stat_errs        (stat_errs),
      .stat_fc          (stat_fc),
`endif
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_sof           (rx_sof),
      .rx_eof           (rx_eof),
      .rx_err           (rx_err),
      .rx_false_carrier (rx_false_carrier)
   );

   int          n_tests = 0, n_fail = 0;
   int          cyc = 0;
   int          hold = 1;
   bit          mon_en = 0;
   logic        pv = 0, pe = 0, pf = 0;
   logic [10:0] act_q[$], exp_q[$];
   int          act_cyc[$];
   logic [2:0]  fq[$];
   int          exp_good = 0, exp_bad = 0, exp_fc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge rmii_ref_clk) cyc <= cyc + 1;

   always @(negedge rmii_ref_clk) begin
      if (mon_en) begin
         check_eq("qualifier", {30'd0, rx_sof & ~rx_valid, rx_err & ~rx_eof}, 0);
         if (rx_valid | rx_eof | rx_false_carrier)
            check_eq("strobe_1cyc", {29'd0, pv & rx_valid, pe & rx_eof, pf & rx_false_carrier}, 0);
         if (rx_eof) check_eq("eof_vs_valid", {31'd0, rx_valid}, 0);
         if (rx_valid) begin
            act_q.push_back({K_VAL, rx_sof, rx_data});
            act_cyc.push_back(cyc);
         end
         if (rx_eof) begin
            act_q.push_back({K_EOF, rx_err, 8'h00});
            act_cyc.push_back(cyc);
         end
         if (rx_false_carrier) begin
            act_q.push_back({K_FC, 1'b0, 8'h00});
            act_cyc.push_back(cyc);
         end
      end
      pv = rx_valid;
      pe = rx_eof;
      pf = rx_false_carrier;
   end

   // Frame model: preamble+SFD, payload bytes LSB-first, optional trailing dibits.
   task automatic build_frame(input logic [7:0] data[$], input bit toggle, input int extra,
                              input int npre);
      int  n = data.size();
      bit  bad;
      fq.delete();
      for (int i = 0; i < npre * 4; i++) fq.push_back({1'b1, 2'b01});
      fq.push_back(3'b101); fq.push_back(3'b101); fq.push_back(3'b101); fq.push_back(3'b111);
      foreach (data[w])
         for (int j = 0; j < 4; j++)
            fq.push_back({(toggle && w > 0) ? j[0] : 1'b1, data[w][2*j +: 2]});
      for (int k = 0; k < extra; k++) fq.push_back({1'b1, 2'($urandom)});
      for (int k = 0; k < 10; k++) fq.push_back(3'b000);
      if (n >= MAX_WORDS) begin
         for (int w = 0; w < MAX_WORDS; w++) exp_q.push_back({K_VAL, 1'(w == 0), data[w]});
         exp_q.push_back({K_EOF, 1'b1, 8'h00});
         exp_bad++;
      end else begin
         for (int w = 0; w < n; w++) exp_q.push_back({K_VAL, 1'(w == 0), data[w]});
         bad = (extra > 0) || (n == 0);
         exp_q.push_back({K_EOF, bad, 8'h00});
         if (bad) exp_bad++;
         else     exp_good++;
      end
   endtask

   task automatic build_fc(input int len);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back({1'b1, 2'b10});
      for (int k = 0; k < 10; k++) fq.push_back(3'b000);
      exp_q.push_back({K_FC, 1'b0, 8'h00});
      exp_fc++;
   endtask

   task automatic play(input int upto, input int mark, output int mark_cyc);
      mark_cyc = -1;
      for (int i = 0; i < upto; i++) begin
         {rmii_rx_crs_dv, rmii_rxd} = fq[i];
         if (i == mark) mark_cyc = cyc;
         repeat (hold) @(posedge rmii_ref_clk);
         #1;
      end
   endtask

   task automatic settle();
      repeat (4 * hold + 6) @(posedge rmii_ref_clk);
      #1;
   endtask

   task automatic set_mode(input bit m10);
      rmii_10T = m10;
      hold     = m10 ? DIV_10T : 1;
      repeat (30) @(posedge rmii_ref_clk);
      #1;
   endtask

   task automatic compare_frame(input string name);
      check_eq({name, "_count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check_eq($sformatf("%s_ev%0d", name, i), {21'd0, act_q[i]}, {21'd0, exp_q[i]});
      act_q.delete();
      act_cyc.delete();
      exp_q.delete();
   endtask

   task automatic run_frame(input string name);
      int mc;
      play(fq.size(), -1, mc);
      settle();
      compare_frame(name);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          mc;
      logic [7:0]  d[$];
      rst_ref_n      = 1'b0;
      rmii_10T       = 1'b0;
      rmii_rx_crs_dv = 1'b0;
      rmii_rxd       = 2'b00;
`ifdef ENET_RX_STAT_EN
      stat_clr       = 1'b0;
`endif
      repeat (4) @(posedge rmii_ref_clk);
      #1;
      check_eq("rst_data", {24'd0, rx_data}, 0);
      check_eq("rst_strobes", {27'd0, rx_valid, rx_sof, rx_eof, rx_err, rx_false_carrier}, 0);
`ifdef ENET_RX_STAT_EN
      check_eq("rst_stats", {stat_frames | stat_errs, stat_fc}, 0);
`endif
      rst_ref_n = 1'b1;
      repeat (3) @(posedge rmii_ref_clk);
      #1;
      mon_en = 1;

      // 100 Mb/s reference frame with latency check on the first word
      d = {8'hA5, 8'h3C};
      build_frame(d, 0, 0, 7);
      play(fq.size(), 28 + 4 + 3, mc);
      settle();
      check_eq("t1_latency", act_cyc.size() > 0 ? act_cyc[0] : -1, mc + SYNC_LV + 2);
      compare_frame("t1");

      // 10 Mb/s: same words, 4 samples of 10 clocks between words
      set_mode(1);
      build_frame(d, 0, 0, 7);
      play(fq.size(), -1, mc);
      settle();
      check_eq("t2_gap", act_cyc.size() > 1 ? act_cyc[1] - act_cyc[0] : -1, 4 * DIV_10T);
      compare_frame("t2");

      build_frame(d, 1, 0, 7);
      run_frame("t3_toggle_10t");
      set_mode(0);
      build_frame(d, 1, 0, 7);
      run_frame("t3_toggle");

      d = {8'hA5};
      build_frame(d, 0, 1, 7);
      run_frame("t4_partial");

      build_fc(8);
      run_frame("t5_fc");

      d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      build_frame(d, 0, 0, 7);
      run_frame("t6_jabber");
      d = {8'hA5, 8'h3C};
      build_frame(d, 0, 0, 7);
      run_frame("t6_next");

      // Reset in the middle of the second word: only the first word is delivered, no EOF
      d = {8'hA5, 8'h3C, 8'h81};
      build_frame(d, 0, 0, 7);
      play(32 + 8 + 2, -1, mc);
      rst_ref_n = 1'b0;
      @(posedge rmii_ref_clk);
      #1;
      check_eq("mid_rst_data", {24'd0, rx_data}, 0);
      check_eq("mid_rst_strobes", {27'd0, rx_valid, rx_sof, rx_eof, rx_err, rx_false_carrier}, 0);
      rmii_rx_crs_dv = 1'b0;
      rmii_rxd       = 2'b00;
      repeat (3) @(posedge rmii_ref_clk);
      #1;
      rst_ref_n = 1'b1;
      settle();
      exp_q.delete();
      exp_q.push_back({K_VAL, 1'b1, 8'hA5});
      exp_good = 0;
      exp_bad  = 0;
      exp_fc   = 0;
      compare_frame("t7_mid_rst");

      for (int it = 0; it < 40; it++) begin
         bit m10;
         int kind, n, extra;
         bit tog;
         m10 = ($urandom_range(0, 2) == 0);
         if (m10 != rmii_10T) set_mode(m10);
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            build_fc($urandom_range(3, 10));
         end else begin
            d.delete();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            tog   = (n > 1) && ($urandom_range(0, 1) == 1);
            extra = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            build_frame(d, tog, extra, $urandom_range(1, 7));
         end
         run_frame($sformatf("rand%0d", it));
      end

`ifdef ENET_RX_STAT_EN
      check_eq("stat_frames", {16'd0, stat_frames}, exp_good);
      check_eq("stat_errs", {16'd0, stat_errs}, exp_bad);
      check_eq("stat_fc", {16'd0, stat_fc}, exp_fc);
      stat_clr = 1'b1;
      @(posedge rmii_ref_clk);
      #1;
      stat_clr = 1'b0;
      check_eq("stat_clr", {stat_frames | stat_errs, stat_fc}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
